// File: rtl/spi_ram_slave.sv
// SPI mode-0 responder emulating a 23LC512-style serial SRAM (READ 0x03 / WRITE 0x02, 16-bit address).
// Inputs are oversampled through SYNC_STAGES flops; no backpressure, the SPI master paces every transfer.
module spi_ram_slave #(
  parameter int MEM_AW      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_core_i,
  input  logic        rst_n_i,
  input  logic        spi_sclk_i,
  input  logic        spi_mosi_i,
  input  logic        spi_cs_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe_o,
  output logic        wr_strobe_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_prev;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   rise, fall, byte_done;

  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  rx_next;
  logic [7:0]  tx_sr;
  logic [15:0] addr_q;
  logic [15:0] addr_inc;
  logic        is_rd_q;

  logic cmd_done, latch_hi, latch_lo, wr_commit, rd_shift;

  logic [7:0] mem [2**MEM_AW];

  // CS resets to "deasserted" so busy_o and the FSM come out of reset idle.
  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_prev & ~cs_s;
  assign fall      = ~sclk_s & sclk_prev & ~cs_s;
  assign byte_done = rise & (bit_cnt == 3'd7);
  assign rx_next   = {rx_sr, mosi_s};
  assign addr_inc  = addr_q + 16'd1;
  assign busy_o    = ~cs_s;

  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = CMD;
        CMD:     if (byte_done) state_d = (rx_next == 8'h03 || rx_next == 8'h02) ? ADDR_HI : IGNORE;
        ADDR_HI: if (byte_done) state_d = ADDR_LO;
        ADDR_LO: if (byte_done) state_d = is_rd_q ? RD_DATA : WR_DATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cmd_done  = 1'b0;
    latch_hi  = 1'b0;
    latch_lo  = 1'b0;
    wr_commit = 1'b0;
    rd_shift  = 1'b0;
    case (state_q)
      CMD:     cmd_done  = byte_done;
      ADDR_HI: latch_hi  = byte_done;
      ADDR_LO: latch_lo  = byte_done;
      WR_DATA: wr_commit = byte_done;
      RD_DATA: rd_shift  = fall;
      default: ;
    endcase
  end

  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt       <= 3'd0;
      rx_sr         <= 7'd0;
      tx_sr         <= 8'd0;
      addr_q        <= 16'd0;
      is_rd_q       <= 1'b0;
      spi_miso_o    <= 1'b0;
      spi_miso_oe_o <= 1'b0;
      wr_strobe_o   <= 1'b0;
      wr_addr_o     <= 16'd0;
      wr_data_o     <= 8'd0;
    end else begin
      wr_strobe_o <= wr_commit;
      if (cs_s) begin
        bit_cnt       <= 3'd0;
        spi_miso_o    <= 1'b0;
        spi_miso_oe_o <= 1'b0;
      end else begin
        if (rise) begin
          rx_sr   <= rx_next[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (cmd_done) is_rd_q <= (rx_next == 8'h03);
        if (latch_hi) addr_q[15:8] <= rx_next;
        if (latch_lo) begin
          addr_q[7:0] <= rx_next;
          tx_sr       <= mem[MEM_AW'({addr_q[15:8], rx_next})];
        end
        if (wr_commit) begin
          wr_addr_o <= addr_q;
          wr_data_o <= rx_next;
          addr_q    <= addr_inc;
        end
        // The fall that shifts out bit 0 also fetches the next byte, so its MSB leads the next rise.
        if (rd_shift) begin
          spi_miso_o    <= tx_sr[7];
          spi_miso_oe_o <= 1'b1;
          if (bit_cnt == 3'd7) begin
            tx_sr  <= mem[MEM_AW'(addr_inc)];
            addr_q <= addr_inc;
          end else begin
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk_core_i) begin
    if (wr_commit) mem[MEM_AW'(addr_q)] <= rx_next;
  end

endmodule

// File: tb/tb_spi_ram_slave.sv
// Bench for spi_ram_slave: bit-banged SPI master, reference byte-array model and write/read scoreboards.
module tb_spi_ram_slave;
  localparam int HP = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs = 1'b1;
  logic        miso, oe, wr_strobe, busy;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  always #5 clk = ~clk;

  spi_ram_slave #(.MEM_AW(8), .SYNC_STAGES(2)) dut (
    .clk_core_i    (clk),
    .rst_n_i       (rst_n),
    .spi_sclk_i    (sclk),
    .spi_mosi_i    (mosi),
    .spi_cs_i      (cs),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (oe),
    .wr_strobe_o   (wr_strobe),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .busy_o        (busy)
  );

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] d; bit known; } rd_t;

  int   checks = 0;
  int   failures = 0;
  wr_t  exp_wr[$];
  rd_t  exp_rd[$];
  wr_t  mon_e;
  logic [7:0] ref_mem [256];
  bit   ref_valid [256];
  logic [7:0] wbuf [16];
  bit   ign_frame = 1'b0;
  bit   ign_oe_seen = 1'b0;
  logic [15:0] last_wr_addr = 16'h0010;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Write-side monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (ign_frame && oe) ign_oe_seen = 1'b1;
    if (wr_strobe) begin
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr got addr=0x%h data=0x%h exp=no strobe", wr_addr, wr_data);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(mon_e.a));
        chk("wr_data", 32'(wr_data), 32'(mon_e.d));
      end
    end
  end

  task automatic check_rd(input logic [7:0] got);
    rd_t e;
    if (exp_rd.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_rd got=0x%h exp=none", got);
    end else begin
      e = exp_rd.pop_front();
      if (e.known) chk("rd_data", 32'(got), 32'(e.d));
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx, output bit oe_all);
    rx = 8'h00;
    oe_all = 1'b1;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi = tx[i];
      wait_cyc(HP);
      sclk = 1'b1;
      rx[i] = miso;
      if (oe !== 1'b1) oe_all = 1'b0;
      wait_cyc(HP);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx);
    logic [7:0] rx;
    bit o;
    xfer_bits(tx, 8, rx, o);
  endtask

  task automatic cs_lo();
    wait_cyc(1);
    cs = 1'b0;
    wait_cyc(HP);
  endtask

  task automatic cs_hi();
    wait_cyc(HP);
    cs = 1'b1;
    wait_cyc(2 * HP);
  endtask

  task automatic frame_write(input logic [15:0] a, input int n);
    cs_lo();
    xfer(8'h02);
    xfer(a[15:8]);
    xfer(a[7:0]);
    for (int k = 0; k < n; k++) begin
      exp_wr.push_back('{a: a, d: wbuf[k]});
      ref_mem[a[7:0]] = wbuf[k];
      ref_valid[a[7:0]] = 1'b1;
      last_wr_addr = a;
      xfer(wbuf[k]);
      a = a + 16'd1;
    end
    cs_hi();
  endtask

  task automatic frame_read(input logic [15:0] a, input int n);
    logic [7:0] rx;
    bit o;
    cs_lo();
    xfer(8'h03);
    xfer(a[15:8]);
    xfer(a[7:0]);
    for (int k = 0; k < n; k++) begin
      exp_rd.push_back('{d: ref_mem[a[7:0]], known: ref_valid[a[7:0]]});
      xfer_bits(8'($urandom), 8, rx, o);
      check_rd(rx);
      chk("rd_oe", 32'(o), 32'd1);
      a = a + 16'd1;
    end
    cs_hi();
  endtask

  initial begin
    logic [7:0] rx;
    bit o;
    logic [15:0] ra;
    int n;

    for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
    wait_cyc(3);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_cyc(4);

    wbuf[0] = 8'hA5; frame_write(16'h0010, 1);
    wbuf[0] = 8'h3C; frame_write(16'h0011, 1);
    frame_read(16'h0010, 2);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; frame_write(16'h00FF, 2);
    frame_read(16'h00FF, 2);
    wbuf[0] = 8'h77; wbuf[1] = 8'h88; frame_write(16'hFFFF, 2);
    frame_read(16'hFFFF, 2);
    frame_read(16'h12FF, 2);

    // Abort mid-byte: the partial data byte must not commit.
    wbuf[0] = 8'h5A; frame_write(16'h0020, 1);
    cs_lo();
    xfer(8'h02); xfer(8'h00); xfer(8'h20);
    xfer_bits(8'hC3, 5, rx, o);
    cs_hi();
    frame_read(16'h0020, 1);

    // Unknown command: rest of the frame must be inert even if it looks like a write.
    cs_lo();
    xfer(8'h9F);
    ign_oe_seen = 1'b0;
    ign_frame = 1'b1;
    xfer(8'h02); xfer(8'h00); xfer(8'h20);
    chk("ign_busy", 32'(busy), 32'd1);
    ign_frame = 1'b0;
    cs_hi();
    chk("ign_oe", 32'(ign_oe_seen), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    frame_read(16'h0020, 1);

    for (int it = 0; it < 24; it++) begin
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
        ra = 16'($urandom);
        frame_write(ra, n);
      end else begin
        ra = {8'($urandom), last_wr_addr[7:0]};
        frame_read(ra, n);
      end
    end

    // Reset in the middle of a read data byte.
    cs_lo();
    xfer(8'h03); xfer(8'h00); xfer(8'h10);
    exp_rd.push_back('{d: ref_mem[8'h10], known: ref_valid[8'h10]});
    xfer_bits(8'h00, 8, rx, o);
    check_rd(rx);
    xfer_bits(8'h00, 3, rx, o);
    wait_cyc(2);
    chk("pre_rst_oe", 32'(oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_miso", 32'(miso), 32'd0);
    chk("mid_rst_oe", 32'(oe), 32'd0);
    chk("mid_rst_strobe", 32'(wr_strobe), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    cs = 1'b1;
    sclk = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(4);
    frame_read(16'h0010, 1);
    wbuf[0] = 8'hE7; wbuf[1] = 8'h19; frame_write(16'h0040, 2);
    frame_read(16'h0040, 2);

    wait_cyc(20);
    chk("wr_pending", 32'(exp_wr.size()), 32'd0);
    chk("rd_pending", 32'(exp_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
